// File: rtl/bls_seq_pkg.sv
// Shared types and helpers for the nibble-serial borrow-lookahead subtract sequencer.
package bls_seq_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int calc_nib(input int width);
      return width / NIB_W;
   endfunction

endpackage

// File: rtl/bls_settle_timer.sv
// Settle down-counter: load arms SETTLE_CYC-1, tc_o pulses on the capture cycle and reloads.
// Latency: first tc_o SETTLE_CYC cycles after load; counts only while en_i is high.
module bls_settle_timer #(
   parameter int SETTLE_CYC = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYC - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tc_o = en_i && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (load_i || tc_o) begin
         cnt_d = RELOAD;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bls_nibble_seq_ctrl.sv
// WIDTH-bit A-B-bin through one external 4-bit slice, LSB nibble first; done WIDTH/4*SETTLE_CYC cycles after accept.
// start is taken only while ready_o; optional signed overflow output under BLS_SEQ_OVF_EN.
module bls_nibble_seq_ctrl
   import bls_seq_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int SETTLE_CYC = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] d_o,
   output logic             bout_o,
   output logic             zero_o,
`ifdef BLS_SEQ_OVF_EN
   output logic             ovf_o,
`endif
   output logic [3:0]       sl_a_o,
   output logic [3:0]       sl_b_o,
   output logic             sl_bin_o,
   input  logic [3:0]       sl_d_i,
   input  logic             sl_bout_i
);

   localparam int NIB = calc_nib(WIDTH);
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, d_q, d_d;
   logic [IW-1:0]    idx_q;
   logic             borrow_q, bout_q, zero_q;
   logic             accept, run, cap, last;
   logic [IW+1:0]    sh;

   assign accept = (state_q == IDLE) && start_i;
   assign run    = (state_q == RUN);
   assign last   = (idx_q == IW'(NIB - 1));
   assign sh     = {idx_q, 2'b00};

   bls_settle_timer #(
      .SETTLE_CYC(SETTLE_CYC)
   ) u_timer (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .load_i(accept),
      .en_i  (run),
      .tc_o  (cap)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = RUN;
         RUN:     if (cap && last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready_o  = (state_q == IDLE);
      busy_o   = run;
      done_o   = (state_q == DONE);
      sl_a_o   = '0;
      sl_b_o   = '0;
      sl_bin_o = 1'b0;
      if (run) begin
         sl_a_o   = NIB_W'(a_q >> sh);
         sl_b_o   = NIB_W'(b_q >> sh);
         sl_bin_o = borrow_q;
      end
   end

   // Full result as it will look after this step's capture; feeds both d and zero.
   assign d_d = (d_q & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(sl_d_i) << sh);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_q      <= '0;
         b_q      <= '0;
         d_q      <= '0;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else if (accept) begin
         a_q      <= a_i;
         b_q      <= b_i;
         borrow_q <= bin_i;
         idx_q    <= '0;
      end else if (cap) begin
         d_q      <= d_d;
         borrow_q <= sl_bout_i;
         idx_q    <= idx_q + IW'(1);
         if (last) begin
            bout_q <= sl_bout_i;
            zero_q <= (d_d == '0);
         end
      end
   end

`ifdef BLS_SEQ_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_q <= 1'b0;
      end else if (!accept && cap && last) begin
         ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sl_d_i[NIB_W-1] != a_q[WIDTH-1]);
      end
   end

   assign ovf_o = ovf_q;
`endif

   assign d_o    = d_q;
   assign bout_o = bout_q;
   assign zero_o = zero_q;

endmodule

// File: tb/tb_bls_nibble_seq_ctrl.sv
// Bench for bls_nibble_seq_ctrl with a behavioural 4-bit slice; expected results queued, checked on done.
module tb_bls_nibble_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        bin = 1'b0;
   logic        ready, busy, done, bout, zero;
   logic [15:0] d;
   logic [3:0]  sl_a, sl_b, sl_d;
   logic        sl_bin, sl_bout;
   logic [4:0]  sl_diff;
`ifdef BLS_SEQ_OVF_EN
   logic        ovf;
`endif

   always #5 clk = ~clk;

   assign sl_diff = {1'b0, sl_a} - {1'b0, sl_b} - {4'b0, sl_bin};
   assign sl_d    = sl_diff[3:0];
   assign sl_bout = sl_diff[4];

   bls_nibble_seq_ctrl #(.WIDTH(16), .SETTLE_CYC(2)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .a_i      (a),
      .b_i      (b),
      .bin_i    (bin),
      .ready_o  (ready),
      .busy_o   (busy),
      .done_o   (done),
      .d_o      (d),
      .bout_o   (bout),
      .zero_o   (zero),
`ifdef BLS_SEQ_OVF_EN
      .ovf_o    (ovf),
`endif
      .sl_a_o   (sl_a),
      .sl_b_o   (sl_b),
      .sl_bin_o (sl_bin),
      .sl_d_i   (sl_d),
      .sl_bout_i(sl_bout)
   );

   typedef struct {
      logic [15:0] d;
      logic        bout;
      logic        zero;
      logic        ovf;
      int          cyc;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.name, "_d"}, {16'h0, d}, {16'h0, e.d});
            chk({e.name, "_bout"}, {31'h0, bout}, {31'h0, e.bout});
            chk({e.name, "_zero"}, {31'h0, zero}, {31'h0, e.zero});
            chk({e.name, "_latency"}, cyc, e.cyc);
`ifdef BLS_SEQ_OVF_EN
            chk({e.name, "_ovf"}, {31'h0, ovf}, {31'h0, e.ovf});
`endif
         end
      end
   end

   task automatic push_exp(input logic [15:0] ed, input logic eb, input logic ez,
                           input logic eo, input string nm);
      exp_t e;
      e.d = ed; e.bout = eb; e.zero = ez; e.ovf = eo;
      e.cyc = cyc + 9;
      e.name = nm;
      sbq.push_back(e);
   endtask

   // Drives one request at a negedge; returns at the first RUN-cycle negedge with start low.
   task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                           input logic [15:0] ed, input logic eb, input logic ez,
                           input logic eo, input bit push, input string nm);
      int w = 0;
      while (ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (ready !== 1'b1) chk({nm, "_ready_timeout"}, {31'h0, ready}, 32'd1);
      a = av; b = bv; bin = bi; start = 1'b1;
      if (push) push_exp(ed, eb, ez, eo, nm);
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'h0, ready}, 32'd1);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_d", {16'h0, d}, 32'h0);
      chk("rst_bout_zero", {30'h0, bout, zero}, 32'h0);
      chk("rst_slice", {23'h0, sl_a, sl_b, sl_bin}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // 1: plain subtraction, 8 busy cycles
      start_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1, "t1");
      repeat (10) @(negedge clk);
      chk("t1_d_held_idle", {16'h0, d}, 32'h1000);

      // 2: borrow ripples through all nibbles
      start_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, "t2");

      // 3: borrow-in consumed in nibble 0 only
      start_op(16'h5A5A, 16'h5A59, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, "t3");
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("t3_busy_%0d", j), {31'h0, busy}, 32'd1);
         chk($sformatf("t3_sl_bin_%0d", j), {31'h0, sl_bin}, (j < 2) ? 32'd1 : 32'd0);
         @(negedge clk);
      end

      // borrow-in with equal operands wraps
      start_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, "t_bin_wrap");

      // 4: start held and operands churned during RUN/DONE
      while (ready !== 1'b1) @(negedge clk);
      a = 16'h0010; b = 16'h0001; bin = 1'b0; start = 1'b1;
      push_exp(16'h000F, 1'b0, 1'b0, 1'b0, "t4a");
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk);
         a = 16'hA5C3 ^ 16'(j * 16'h1111);
         b = 16'h3C5A + 16'(j);
         bin = j[0];
         if (j <= 8) chk($sformatf("t4_busy_%0d", j), {31'h0, busy}, 32'd1);
      end
      @(negedge clk);
      chk("t4_first_idle_ready", {31'h0, ready}, 32'd1);
      a = 16'h00FF; b = 16'h000F; bin = 1'b0;
      push_exp(16'h00F0, 1'b0, 1'b0, 1'b0, "t4b");
      @(negedge clk);
      start = 1'b0;
      chk("t4b_accepted", {31'h0, busy}, 32'd1);

      // 5: reset after the second capture discards the operation
      start_op(16'hFFFF, 16'h1111, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, "t5");
      repeat (4) @(negedge clk);
      chk("t5_two_nibbles", {16'h0, d}, 32'h00EE);
      rst = 1'b1;
      #1;
      chk("t5_rst_busy", {31'h0, busy}, 32'd0);
      chk("t5_rst_ready", {31'h0, ready}, 32'd1);
      chk("t5_rst_d", {16'h0, d}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_op(16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, "t5_after");

`ifdef BLS_SEQ_OVF_EN
      // 6: signed overflow flag
      start_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1, "t6a");
      start_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, "t6b");
`endif

      for (int w = 0; w < 100 && sbq.size() != 0; w++) @(negedge clk);
      if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 32'd0);
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bls_nibble_seq_ctrl.md
Name: bls_nibble_seq_ctrl

Overview:
Sequencer that performs a WIDTH-bit subtraction D = A - B - bin by time-multiplexing one external 4-bit borrow-lookahead subtractor slice, one nibble per step, LSB nibble first.
Owns the start/busy/done handshake, the nibble index, the inter-nibble borrow register and the result register.
Sits between a requester and the gate-level 4-bit slice. The slice is instantiated at the top level beside this block.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
SETTLE_CYC, 2, clock cycles each nibble's slice inputs are held before capture; must be at least 1. Constraint: SETTLE_CYC * Tclk > worst-case slice propagation delay.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  request; accepted only when ready=1
a  in  WIDTH  minuend, sampled on the accepting edge
b  in  WIDTH  subtrahend, sampled on the accepting edge
bin  in  1  borrow-in, sampled on the accepting edge
ready  out  1  high in IDLE only
busy  out  1  high in RUN
done  out  1  one-cycle pulse; result valid
d  out  WIDTH  result register
bout  out  1  final borrow-out, registered
zero  out  1  registered flag, d == 0
sl_a  out  4  slice A input
sl_b  out  4  slice B input
sl_bin  out  1  slice borrow-in
sl_d  in  4  slice difference output
sl_bout  in  1  slice borrow-out

Behaviour:
- Reset values:
  - State is IDLE.
  - d = 0, bout = 0, zero = 0, done = 0, busy = 0, ready = 1.
  - Nibble index, settle count and operand registers are 0.
  - Borrow register is 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a, b and bin (bin goes into the borrow register). Clear the nibble index and settle count. Go to RUN.
  - d, bout and zero are not cleared; they keep the previous result until overwritten.
- RUN:
  - sl_a = a_reg[4i+3:4i], sl_b = b_reg[4i+3:4i], sl_bin = borrow register. All three are combinational from registers, so they are glitch-free and stable for the whole step.
  - The settle count increments every cycle.
  - On the edge where the count reaches SETTLE_CYC-1: capture d[4i+3:4i] <= sl_d and borrow <= sl_bout, clear the count, increment i.
  - On the last nibble's capture edge also load bout <= sl_bout and zero <= (full next d == 0), then go to DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- Slice inputs are driven to 0 in IDLE and DONE.
- Latency: start accepted at edge k. Captures occur at edges k + SETTLE_CYC*(i+1). done is high during the cycle after edge k + NIB*SETTLE_CYC, where NIB = WIDTH/4. ready returns one cycle later.
- Defaults (WIDTH=16, SETTLE_CYC=2): 8 busy cycles.
- start while in RUN or DONE is ignored; operands are not re-sampled.
- Back-to-back operation: start held high through DONE is accepted in the following IDLE cycle.
- Final borrow wrap-around: bout=1 means A < B + bin (unsigned); d holds the result mod 2^WIDTH.
- Reset asserted mid-RUN or in DONE:
  - Immediately returns to IDLE with all reset values; the partial result is discarded.
  - The first operation after reset deassertion is unaffected.

Optional Feature:
Macro BLS_SEQ_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0).
  - On the final capture edge, ovf <= (a_reg[MSB] != b_reg[MSB]) && (sl_d[3] != a_reg[MSB]). This is signed two's-complement overflow.
  - ovf holds until the next completion or reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package bls_seq_pkg contains:
  - the state typedef (IDLE, RUN, DONE);
  - the constant NIB_W = 4;
  - a function computing NIB from WIDTH.
- One sub-module is natural: bls_settle_timer. It has a parameterised down-counter with load and a terminal-count output, and drives the capture strobe.
- The nibble mux and capture logic stay in the top module.

Test Plan:
1. a=0x1234, b=0x0234, bin=0, start at edge k -> done in the cycle after edge k+8; d=0x1000, bout=0, zero=0.
2. a=0x0000, b=0x0001, bin=0 -> borrow ripples through all 4 nibbles; d=0xFFFF, bout=1, zero=0.
3. a=0x5A5A, b=0x5A59, bin=1 -> d=0x0000, bout=0, zero=1; confirm sl_bin=1 during nibble 0 only.
4. Start 0x0010-0x0001. Hold start high and change a/b every cycle during RUN -> result 0x000F, unaffected. A second op is accepted only in the first IDLE cycle.
5. Assert rst after the 2nd capture of 0xFFFF-0x1111 -> same cycle busy=0, ready=1, d=0. After release, 0x0003-0x0001 gives d=0x0002.
6. (BLS_SEQ_OVF_EN) a=0x8000, b=0x0001 -> d=0x7FFF, bout=0, ovf=1. Then a=0x0005, b=0x0003 -> d=0x0002, ovf=0.
